// File: rtl/single_port_memory_arbiter.sv
// Two-port arbiter for one single-port RAM: zero-sweeps the RAM after reset, then grants one access per cycle.
// Read data returns one cycle after acceptance, and losing requesters hold on ready=0. Define SPM_ARB_ROUND_ROBIN_EN for round-robin grants.
module single_port_memory_arbiter #(
    parameter int DATAWIDTH    = 8,
    parameter int DATADEPTH    = 1024,
    parameter int ADDRESSWIDTH = $clog2(DATADEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic                    req0_write,
    input  logic [ADDRESSWIDTH-1:0] req0_address,
    input  logic [DATAWIDTH-1:0]    req0_data,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic                    req1_write,
    input  logic [ADDRESSWIDTH-1:0] req1_address,
    input  logic [DATAWIDTH-1:0]    req1_data,
    output logic                    rsp0_valid,
    output logic [DATAWIDTH-1:0]    rsp0_data,
    output logic                    rsp1_valid,
    output logic [DATAWIDTH-1:0]    rsp1_data,
    output logic                    init_done,
    output logic                    mem_write_en,
    output logic [DATAWIDTH-1:0]    mem_data_in,
    output logic [ADDRESSWIDTH-1:0] mem_address,
    input  logic [DATAWIDTH-1:0]    mem_data_out
);
    typedef enum logic {ST_INIT, ST_SERVE} state_e;

    typedef struct packed {
        logic                    write;
        logic [ADDRESSWIDTH-1:0] addr;
        logic [DATAWIDTH-1:0]    data;
    } req_t;

    localparam logic [ADDRESSWIDTH-1:0] LAST_ADDR = ADDRESSWIDTH'(DATADEPTH - 1);
    localparam logic [ADDRESSWIDTH-1:0] ADDR_ONE  = ADDRESSWIDTH'(1);

    state_e                  state_q, state_d;
    logic [ADDRESSWIDTH-1:0] cnt_q, cnt_d;
    logic [ADDRESSWIDTH-1:0] addr_q;
    logic [DATAWIDTH-1:0]    data_q;
    logic                    rsp_vld_q, rsp_vld_d;
    logic                    rsp_own_q, rsp_own_d;
    logic                    gnt_port;
    logic                    gnt_vld;
    logic                    serve;
    logic                    accept;
    req_t                    req0, req1, sel;

    assign req0 = {req0_write, req0_address, req0_data};
    assign req1 = {req1_write, req1_address, req1_data};

`ifdef SPM_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;

    // On a tie the port that did not win last time goes next.
    always_comb begin
        if (req0_valid && req1_valid) begin
            gnt_port = ~last_q;
        end else begin
            gnt_port = ~req0_valid;
        end
    end

    assign last_d = accept ? gnt_port : last_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign gnt_port = ~req0_valid;
`endif

    assign gnt_vld    = req0_valid | req1_valid;
    assign serve      = (state_q == ST_SERVE) && !reset;
    assign accept     = serve && gnt_vld;
    assign req0_ready = accept && !gnt_port;
    assign req1_ready = accept && gnt_port;
    assign sel        = gnt_port ? req1 : req0;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rsp_vld_d    = 1'b0;
        rsp_own_d    = rsp_own_q;
        mem_write_en = 1'b0;
        mem_address  = addr_q;
        mem_data_in  = data_q;
        case (state_q)
            ST_INIT: begin
                mem_write_en = 1'b1;
                mem_address  = cnt_q;
                mem_data_in  = '0;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_SERVE;
                end else begin
                    cnt_d = cnt_q + ADDR_ONE;
                end
            end
            ST_SERVE: begin
                if (accept) begin
                    mem_write_en = sel.write;
                    mem_address  = sel.addr;
                    mem_data_in  = sel.data;
                    rsp_vld_d    = !sel.write;
                    rsp_own_d    = gnt_port;
                end
            end
            default: state_d = ST_INIT;
        endcase
        if (reset) begin
            mem_write_en = 1'b0;
        end
    end

    // Address and data registers let an idle cycle replay the last values on the RAM pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            rsp_vld_q <= 1'b0;
            rsp_own_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= mem_address;
            data_q    <= mem_data_in;
            rsp_vld_q <= rsp_vld_d;
            rsp_own_q <= rsp_own_d;
        end
    end

    // A reset arriving while a response is due suppresses it in that same cycle.
    assign rsp0_valid = rsp_vld_q && !rsp_own_q && !reset;
    assign rsp1_valid = rsp_vld_q && rsp_own_q && !reset;
    assign rsp0_data  = mem_data_out;
    assign rsp1_data  = mem_data_out;
    assign init_done  = (state_q == ST_SERVE);

endmodule

// File: tb/tb_single_port_memory_arbiter.sv
// Directed bench for single_port_memory_arbiter with a behavioural synchronous RAM (DATADEPTH=16).
module tb_single_port_memory_arbiter;
    localparam int DW = 8;
    localparam int DD = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req0_ready, req0_write;
    logic [AW-1:0] req0_address;
    logic [DW-1:0] req0_data;
    logic          req1_valid, req1_ready, req1_write;
    logic [AW-1:0] req1_address;
    logic [DW-1:0] req1_data;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_data, rsp1_data;
    logic          init_done, mem_write_en;
    logic [DW-1:0] mem_data_in, mem_data_out;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem [DD];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write_en) mem[mem_address] <= mem_data_in;
        mem_data_out <= mem[mem_address];
    end

    single_port_memory_arbiter #(
        .DATAWIDTH   (DW),
        .DATADEPTH   (DD),
        .ADDRESSWIDTH(AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_write  (req0_write),
        .req0_address(req0_address),
        .req0_data   (req0_data),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_write  (req1_write),
        .req1_address(req1_address),
        .req1_data   (req1_data),
        .rsp0_valid  (rsp0_valid),
        .rsp0_data   (rsp0_data),
        .rsp1_valid  (rsp1_valid),
        .rsp1_data   (rsp1_data),
        .init_done   (init_done),
        .mem_write_en(mem_write_en),
        .mem_data_in (mem_data_in),
        .mem_address (mem_address),
        .mem_data_out(mem_data_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic drive0(input logic v, input logic w, input int a, input logic [DW-1:0] d);
        req0_valid = v; req0_write = w; req0_address = AW'(a); req0_data = d;
    endtask

    task automatic drive1(input logic v, input logic w, input int a, input logic [DW-1:0] d);
        req1_valid = v; req1_write = w; req1_address = AW'(a); req1_data = d;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic samp;
        @(negedge clk);
    endtask

    initial begin
        int   rise;
        int   addr_err;
        int   zero_bad;
        logic rdy_seen;
        logic rsp_seen;
        logic prev;
        logic exp_g;

        reset = 1'b1;
        drive0(0, 0, 0, 8'h00);
        drive1(0, 0, 0, 8'h00);
        tick;
        tick;
        samp;
        chk("rst_rdy", 32'({req1_ready, req0_ready}), 0);
        chk("rst_rsp", 32'({rsp1_valid, rsp0_valid}), 0);
        chk("rst_done", 32'(init_done), 0);
        chk("rst_we_forced", 32'(mem_write_en), 0);
        chk("rst_addr", 32'(mem_address), 0);

        // Release reset with both requesters already waiting.
        tick;
        reset = 1'b0;
        drive0(1, 0, 7, 8'h00);
        drive1(1, 0, 9, 8'h00);
        samp;
        chk("init_first", 32'({mem_write_en, mem_address, mem_data_in}), 32'({1'b1, 4'h0, 8'h00}));
        rdy_seen = req0_ready | req1_ready;
        rise     = init_done ? 1 : 0;
        addr_err = 0;
        for (int k = 2; k <= 20; k++) begin
            tick;
            if (k == 17) begin
                drive0(0, 0, 0, 8'h00);
                drive1(0, 0, 0, 8'h00);
            end
            samp;
            if (k <= 16) begin
                rdy_seen = rdy_seen | req0_ready | req1_ready;
                if (mem_address !== AW'(k - 1) || mem_write_en !== 1'b1) addr_err++;
            end
            if (init_done === 1'b1 && rise == 0) rise = k;
        end
        chk("init_rise_cycle", 32'(rise), 17);
        chk("init_rdy_quiet", 32'(rdy_seen), 0);
        chk("init_sweep_addr", 32'(addr_err), 0);

        zero_bad = 0;
        for (int a = 0; a < DD; a++) begin
            tick;
            if (a % 2 == 0) drive0(1, 0, a, 8'h00);
            else            drive1(1, 0, a, 8'h00);
            tick;
            drive0(0, 0, 0, 8'h00);
            drive1(0, 0, 0, 8'h00);
            samp;
            if (a % 2 == 0) begin
                if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp0_data !== 8'h00) zero_bad++;
            end else begin
                if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp1_data !== 8'h00) zero_bad++;
            end
        end
        chk("zero_sweep_reads", 32'(zero_bad), 0);

        // Write then read of the same address on back-to-back cycles.
        tick;
        drive0(1, 1, 3, 8'hA5);
        samp;
        chk("wr_rdy0", 32'({req1_ready, req0_ready}), 32'(2'b01));
        tick;
        drive0(0, 0, 0, 8'h00);
        drive1(1, 0, 3, 8'h00);
        samp;
        chk("rd_rdy1", 32'({req1_ready, req0_ready}), 32'(2'b10));
        chk("wr_no_rsp", 32'({rsp1_valid, rsp0_valid}), 0);
        tick;
        drive1(0, 0, 0, 8'h00);
        samp;
        chk("raw_rsp_vld", 32'({rsp1_valid, rsp0_valid}), 32'(2'b10));
        chk("raw_rsp_data", 32'(rsp1_data), 32'h0000_00A5);
        chk("idle_we", 32'(mem_write_en), 0);
        chk("idle_addr_hold", 32'(mem_address), 3);

        tick;
        drive1(1, 1, 5, 8'h11);
        tick;
        drive1(0, 0, 0, 8'h00);

        // Both ports stream reads: port 0 reads 0xA5, port 1 reads 0x11.
        drive0(1, 0, 3, 8'h00);
        drive1(1, 0, 5, 8'h00);
        prev = 1'b0;
        for (int i = 0; i < 9; i++) begin
            samp;
`ifdef SPM_ARB_ROUND_ROBIN_EN
            exp_g = (i % 2 == 1);
`else
            exp_g = 1'b0;
`endif
            if (i < 8) chk("arb_rdy", 32'({req1_ready, req0_ready}), exp_g ? 32'(2'b10) : 32'(2'b01));
            if (i > 0) begin
                if (prev) chk("arb_rsp1", 32'({rsp1_valid, rsp0_valid, rsp1_data}), 32'({2'b10, 8'h11}));
                else      chk("arb_rsp0", 32'({rsp1_valid, rsp0_valid, rsp0_data}), 32'({2'b01, 8'hA5}));
            end
            prev = exp_g;
            tick;
            if (i == 7) begin
                drive0(0, 0, 0, 8'h00);
                drive1(0, 0, 0, 8'h00);
            end
        end

        // Read then write of the same address: the read sees the old word.
        drive0(1, 0, 5, 8'h00);
        tick;
        drive0(1, 1, 5, 8'h22);
        samp;
        chk("war_rsp_old", 32'({rsp0_valid, rsp0_data}), 32'({1'b1, 8'h11}));
        tick;
        drive0(1, 0, 5, 8'h00);
        samp;
        chk("war_wr_no_rsp", 32'({rsp1_valid, rsp0_valid}), 0);
        tick;
        drive0(0, 0, 0, 8'h00);
        samp;
        chk("war_rd_new", 32'({rsp0_valid, rsp0_data}), 32'({1'b1, 8'h22}));

        // Reset lands in the cycle the read response is due.
        tick;
        drive0(1, 0, 5, 8'h00);
        tick;
        reset = 1'b1;
        drive0(0, 0, 0, 8'h00);
        samp;
        chk("rst_drop_rsp", 32'({rsp1_valid, rsp0_valid}), 0);
        chk("rst_we_low", 32'(mem_write_en), 0);
        tick;
        reset = 1'b0;
        samp;
        chk("reinit_done_low", 32'(init_done), 0);
        chk("reinit_addr0", 32'({mem_write_en, mem_address}), 32'({1'b1, 4'h0}));
        rise     = 0;
        rsp_seen = rsp0_valid | rsp1_valid;
        for (int k = 2; k <= 20; k++) begin
            tick;
            samp;
            rsp_seen = rsp_seen | rsp0_valid | rsp1_valid;
            if (init_done === 1'b1 && rise == 0) rise = k;
        end
        chk("reinit_rise_cycle", 32'(rise), 17);
        chk("reinit_no_rsp", 32'(rsp_seen), 0);

        tick;
        drive1(1, 0, 5, 8'h00);
        tick;
        drive1(0, 0, 0, 8'h00);
        samp;
        chk("post_reinit_zero", 32'({rsp1_valid, rsp1_data}), 32'({1'b1, 8'h00}));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
